// File: rtl/seven_segment_scanner.sv
// -----------------------------------------------------------------------------
// seven_segment_scanner
//
// Purpose:
//   Time-multiplexes one shared seven-segment decoder across NUM_DIGITS
//   common-anode digits. Each digit position gets BLANK_CYCLES cycles with
//   every anode off. It then gets DWELL_CYCLES cycles lit. The displayed BCD
//   value is double-buffered: a load lands in a shadow register, and that
//   register is copied into the active buffer only when the digit index wraps
//   to 0. A frame is therefore never torn.
//
// Ports:
//   clk         in   system clock, all logic on the rising edge
//   reset       in   synchronous, active-high
//   enable      in   1 = scan; 0 = all anodes off and the sequencer frozen
//   load        in   1-cycle strobe that captures value_in into the shadow buffer
//   value_in    in   4*NUM_DIGITS BCD nibbles; [3:0] is digit 0
//   digit_code  out  nibble sent to the decoder; 4'hF = blank
//   anode_n     out  active-low digit enables; bit i = digit i
//   pending     out  the shadow holds a value that is not yet committed
//   frame_tick  out  1-cycle pulse when the digit index wraps to 0
//
// Configuration:
//   LEADING_ZERO_BLANK_EN  when defined, a digit i > 0 is blanked while its
//                          active nibble and every higher nibble are zero.
//                          Digit 0 is always shown.
// -----------------------------------------------------------------------------
module seven_segment_scanner #(
  parameter int NUM_DIGITS   = 4,
  parameter int DWELL_CYCLES = 50000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] value_in,
  output logic [3:0]              digit_code,
  output logic [NUM_DIGITS-1:0]   anode_n,
  output logic                    pending,
  output logic                    frame_tick
);

  localparam int MAX_CYCLES = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES + 1);
  localparam int IW         = $clog2(NUM_DIGITS);

  localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL_CYCLES - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
  localparam logic [IW-1:0] INDEX_LAST = IW'(NUM_DIGITS - 1);

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_DRIVE = 1'b1
  } state_t;

  state_t                  state_q, state_d;
  logic [IW-1:0]           index_q, index_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [4*NUM_DIGITS-1:0] active_q, active_d;
  logic [4*NUM_DIGITS-1:0] shadow_q, shadow_d;
  logic                    pending_q, pending_d;
  logic [3:0]              digit_code_q, digit_code_d;
  logic [NUM_DIGITS-1:0]   anode_n_q, anode_n_d;
  logic                    frame_tick_q, frame_tick_d;

  logic                    wrap;
  logic [3:0]              drive_code;
  logic [3:0]              nib [NUM_DIGITS];

  // Split the active buffer into one nibble per digit.
  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_nib
    assign nib[gi] = active_q[gi*4 +: 4];
  end

`ifdef LEADING_ZERO_BLANK_EN
  // upper_zero[i] is set when nibble i and every nibble above it are zero.
  logic [NUM_DIGITS-1:0] upper_zero;
  logic                  zero_run;

  always_comb begin
    upper_zero = '0;
    zero_run   = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      zero_run      = zero_run && (nib[i] == 4'h0);
      upper_zero[i] = zero_run;
    end
  end

  always_comb begin
    drive_code = nib[index_q];
    if ((index_q != '0) && upper_zero[index_q]) begin
      drive_code = 4'hF;
    end
  end
`else
  always_comb begin
    drive_code = nib[index_q];
  end
`endif

  // Sequencer: BLANK -> DRIVE -> next index. When enable is low, the
  // sequencer is frozen where it is.
  always_comb begin
    state_d = state_q;
    index_d = index_q;
    cnt_d   = cnt_q;
    wrap    = 1'b0;
    if (enable) begin
      case (state_q)
        ST_BLANK: begin
          // With no blanking gap configured, BLANK only appears once after reset.
          if ((BLANK_CYCLES == 0) || (cnt_q == BLANK_LAST)) begin
            state_d = ST_DRIVE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        ST_DRIVE: begin
          if (cnt_q == DWELL_LAST) begin
            cnt_d   = '0;
            wrap    = (index_q == INDEX_LAST);
            index_d = wrap ? '0 : index_q + 1'b1;
            state_d = (BLANK_CYCLES == 0) ? ST_DRIVE : ST_BLANK;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: begin
          state_d = ST_BLANK;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Double buffer. A commit copies the shadow value that existed before this
  // edge. A load in the same cycle still lands in the shadow and keeps
  // pending set.
  always_comb begin
    active_d  = active_q;
    shadow_d  = shadow_q;
    pending_d = pending_q;
    if (wrap && pending_q) begin
      active_d  = shadow_q;
      pending_d = 1'b0;
    end
    if (load) begin
      shadow_d  = value_in;
      pending_d = 1'b1;
    end
  end

  // Output stage. These values come from the current state and are
  // registered, so the pins follow the sequencer one cycle later.
  always_comb begin
    anode_n_d    = '1;
    digit_code_d = 4'hF;
    frame_tick_d = wrap;
    if (enable && (state_q == ST_DRIVE)) begin
      anode_n_d[index_q] = 1'b0;
      digit_code_d       = drive_code;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_BLANK;
      index_q      <= '0;
      cnt_q        <= '0;
      active_q     <= '1;
      shadow_q     <= '1;
      pending_q    <= 1'b0;
      digit_code_q <= 4'hF;
      anode_n_q    <= '1;
      frame_tick_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      index_q      <= index_d;
      cnt_q        <= cnt_d;
      active_q     <= active_d;
      shadow_q     <= shadow_d;
      pending_q    <= pending_d;
      digit_code_q <= digit_code_d;
      anode_n_q    <= anode_n_d;
      frame_tick_q <= frame_tick_d;
    end
  end

  assign digit_code = digit_code_q;
  assign anode_n    = anode_n_q;
  assign pending    = pending_q;
  assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_seven_segment_scanner.sv
// -----------------------------------------------------------------------------
// tb_seven_segment_scanner
//
// Purpose:
//   Self-checking bench for seven_segment_scanner with NUM_DIGITS=4,
//   DWELL_CYCLES=4 and BLANK_CYCLES=2, which gives a 24-cycle frame. The
//   reference model tracks the scan as a single position inside the frame.
//   The lit digit and the blanking window are derived from that position
//   with division and modulo. The model applies the double-buffer rules to
//   whole 16-bit values.
// -----------------------------------------------------------------------------
module tb_seven_segment_scanner;

  localparam int ND    = 4;
  localparam int DWELL = 4;
  localparam int BLANK = 2;
  localparam int SEG   = BLANK + DWELL;
  localparam int FRAME = ND * SEG;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic        load = 1'b0;
  logic [15:0] value_in = 16'h0;
  logic [3:0]  digit_code;
  logic [3:0]  anode_n;
  logic        pending;
  logic        frame_tick;

  int vectors = 0;
  int miscompares = 0;
  int cycle = 0;

  // Reference model state
  int          m_pos;
  logic [15:0] m_active;
  logic [15:0] m_shadow;
  logic        m_pending;
  logic [3:0]  exp_anode;
  logic [3:0]  exp_code;
  logic        exp_tick;

  always #5 clk = ~clk;

  seven_segment_scanner #(
    .NUM_DIGITS  (ND),
    .DWELL_CYCLES(DWELL),
    .BLANK_CYCLES(BLANK)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .load      (load),
    .value_in  (value_in),
    .digit_code(digit_code),
    .anode_n   (anode_n),
    .pending   (pending),
    .frame_tick(frame_tick)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s @cycle %0d: got %h expected %h", tag, cycle, got, exp);
    end
  endtask

  // Digit shown for a given value. With leading-zero blanking, a digit above
  // the top non-zero nibble is blank.
  function automatic logic [3:0] shown_code(input logic [15:0] val, input int digit);
    logic [15:0] upper;
    upper = val >> (4 * digit);
`ifdef LEADING_ZERO_BLANK_EN
    if ((digit > 0) && (upper == 16'h0)) return 4'hF;
`endif
    return upper[3:0];
  endfunction

  // One clock: drive the inputs, let the edge happen, advance the model, then
  // compare every output.
  task automatic step(input logic rst, input logic en, input logic ld, input logic [15:0] v);
    int  digit;
    int  off;
    logic commit;
    @(negedge clk);
    reset    = rst;
    enable   = en;
    load     = ld;
    value_in = v;
    @(posedge clk);
    cycle++;
    if (rst) begin
      m_pos     = 0;
      m_active  = 16'hFFFF;
      m_shadow  = 16'hFFFF;
      m_pending = 1'b0;
      exp_anode = 4'b1111;
      exp_code  = 4'hF;
      exp_tick  = 1'b0;
    end else begin
      digit = m_pos / SEG;
      off   = m_pos % SEG;
      if (en && (off >= BLANK)) begin
        exp_anode = ~(4'b0001 << digit);
        exp_code  = shown_code(m_active, digit);
      end else begin
        exp_anode = 4'b1111;
        exp_code  = 4'hF;
      end
      exp_tick = en && (m_pos == FRAME - 1);
      commit   = exp_tick && m_pending;
      if (commit) begin
        m_active  = m_shadow;
        m_pending = 1'b0;
      end
      if (ld) begin
        m_shadow  = v;
        m_pending = 1'b1;
      end
      if (en) m_pos = (m_pos + 1) % FRAME;
    end
    #1;
    check_val("anode_n", 32'(anode_n), 32'(exp_anode));
    check_val("digit_code", 32'(digit_code), 32'(exp_code));
    check_val("pending", 32'(pending), 32'(m_pending));
    check_val("frame_tick", 32'(frame_tick), 32'(exp_tick));
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b1, 1'b0, 16'h0);
  endtask

  // Advance with enable high until the model reaches the given frame position.
  task automatic run_to(input int pos);
    int guard;
    guard = 0;
    while ((m_pos != pos) && (guard < 2 * FRAME)) begin
      step(1'b0, 1'b1, 1'b0, 16'h0);
      guard++;
    end
  endtask

  initial begin
    int last_tick;

    // Reset state
    step(1'b1, 1'b0, 1'b0, 16'h0);
    step(1'b1, 1'b1, 1'b0, 16'h0);
    check_val("reset_anode", 32'(anode_n), 32'hF);
    check_val("reset_code", 32'(digit_code), 32'hF);
    check_val("reset_pending", 32'(pending), 32'h0);
    check_val("reset_tick", 32'(frame_tick), 32'h0);

    // Free-running scan with blank digits. Also check the frame period.
    last_tick = -1;
    for (int i = 0; i < 3 * FRAME; i++) begin
      step(1'b0, 1'b1, 1'b0, 16'h0);
      if (frame_tick === 1'b1) begin
        if (last_tick >= 0) check_val("tick_period", 32'(cycle - last_tick), 32'(FRAME));
        last_tick = cycle;
      end
    end

    // Load mid-frame; the display changes only after the wrap.
    run_to(7);
    step(1'b0, 1'b1, 1'b1, 16'h1234);
    run(2 * FRAME);

    // The last of two loads before the wrap wins.
    run_to(3);
    step(1'b0, 1'b1, 1'b1, 16'h1111);
    run(5);
    step(1'b0, 1'b1, 1'b1, 16'h5678);
    run(2 * FRAME);

    // A load in the commit cycle: the old shadow commits and pending stays set.
    run_to(4);
    step(1'b0, 1'b1, 1'b1, 16'h4321);
    run_to(FRAME - 1);
    step(1'b0, 1'b1, 1'b1, 16'h9876);
    check_val("commit_load_pending", 32'(pending), 32'h1);
    run(2 * FRAME);

    // Pause for 10 cycles in the middle of digit 2's dwell.
    run_to(2 * SEG + BLANK + 1);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 1'b0, 16'h0);
    run(FRAME + 4);

    // Leading zeros.
    step(1'b0, 1'b1, 1'b1, 16'h0070);
    run(2 * FRAME);
    step(1'b0, 1'b1, 1'b1, 16'h0000);
    run(2 * FRAME);

    // Randomised traffic, including nibbles above 9.
    for (int i = 0; i < 600; i++) begin
      step(1'b0, ($urandom_range(0, 9) != 0), ($urandom_range(0, 19) == 0), 16'($urandom));
    end

    // Reset mid-frame discards a pending value.
    run_to(9);
    step(1'b0, 1'b1, 1'b1, 16'hABCD);
    step(1'b1, 1'b1, 1'b0, 16'h0);
    check_val("midreset_pending", 32'(pending), 32'h0);
    run(2 * FRAME);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
